// File: rtl/norm_shift_ctrl_pkg.sv
// Shared defaults, group width and shift-direction encodings for norm_shift_ctrl.
package norm_shift_ctrl_pkg;

    localparam int SWR_DEF = 26;
    localparam int EWR_DEF = 5;
    localparam int EW_DEF  = 8;
    localparam int GRP_W   = 4;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    localparam logic LEFT  = DIR_LEFT;
    localparam logic RIGHT = DIR_RIGHT;

    // Number of GRP_W-wide groups needed to cover w bits (low end padded).
    function automatic int num_groups(input int w);
        return (w + GRP_W - 1) / GRP_W;
    endfunction

endpackage

// File: rtl/norm_shift_ctrl_lzd_nibble.sv
// 4-bit leading-zero encoder: zero flag plus 2-bit count of leading zeros.
module LZD_Nibble (
    input  logic [3:0] data,
    output logic       zero,
    output logic [1:0] count
);

    always_comb begin
        zero  = 1'b0;
        count = 2'd0;
        casez (data)
            4'b1???: count = 2'd0;
            4'b01??: count = 2'd1;
            4'b001?: count = 2'd2;
            4'b0001: count = 2'd3;
            default: zero  = 1'b1;
        endcase
    end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalization shift controller: input register, per-nibble LZD stage, merge/output stage.
// Optional exponent underflow detection is enabled by defining NORM_UNDERFLOW_DET_EN.
module norm_shift_ctrl
    import norm_shift_ctrl_pkg::*;
#(
    parameter int SWR = SWR_DEF,
    parameter int EWR = EWR_DEF,
    parameter int EW  = EW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Data_i,
    input  logic [EW-1:0]  Exp_i,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           left_right_o,
    output logic [EW-1:0]  Exp_o,
    output logic           zero_o,
    output logic           overflow_o,
    output logic           underflow_o,
    output logic           valid_o,
    output logic           load_o
);

    localparam int LW = SWR - 1;
    localparam int NG = num_groups(LW);
    localparam int PW = NG * GRP_W;

    generate
        if (SWR - 2 > (2 ** EWR) - 1) begin : g_bad_ewr
            $error("norm_shift_ctrl: SWR-2 does not fit in EWR bits");
        end
    endgenerate

    // Input capture: the operand sampled by load_i at edge N.
    logic           in_valid_reg;
    logic [SWR-1:0] in_data_reg;
    logic [EW-1:0]  in_exp_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_reg <= 1'b0;
            in_data_reg  <= '0;
            in_exp_reg   <= '0;
        end else begin
            in_valid_reg <= load_i;
            if (load_i) begin
                in_data_reg <= Data_i;
                in_exp_reg  <= Exp_i;
            end
        end
    end

    // Stage 1: per-group leading-zero encoding over the carry-less significand.
    logic [PW-1:0]        padded;
    logic [NG-1:0]        grp_zero;
    logic [NG-1:0][1:0]   grp_cnt;

    assign padded = PW'(in_data_reg[SWR-2:0]) << (PW - LW);

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_lzd
            LZD_Nibble u_lzd (
                .data  (padded[gi*GRP_W +: GRP_W]),
                .zero  (grp_zero[gi]),
                .count (grp_cnt[gi])
            );
        end
    endgenerate

    logic                s1_valid_reg;
    logic                s1_carry_reg;
    logic [EW-1:0]       s1_exp_reg;
    logic                s1_zero_reg;
    logic [NG-1:0]       s1_grp_zero_reg;
    logic [NG-1:0][1:0]  s1_grp_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_carry_reg    <= 1'b0;
            s1_exp_reg      <= '0;
            s1_zero_reg     <= 1'b0;
            s1_grp_zero_reg <= '0;
            s1_grp_cnt_reg  <= '0;
        end else begin
            s1_valid_reg    <= in_valid_reg;
            s1_carry_reg    <= in_data_reg[SWR-1];
            s1_exp_reg      <= in_exp_reg;
            s1_zero_reg     <= (&grp_zero) & ~in_data_reg[SWR-1];
            s1_grp_zero_reg <= grp_zero;
            s1_grp_cnt_reg  <= grp_cnt;
        end
    end

    // Stage 2: the most significant non-empty group determines LZ.
    logic [EWR-1:0] lz;
    logic           lz_found;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (!lz_found && !s1_grp_zero_reg[g]) begin
                lz       = EWR'((NG - 1 - g) * GRP_W) + EWR'(s1_grp_cnt_reg[g]);
                lz_found = 1'b1;
            end
        end
    end

    logic [EW-1:0]  exp_inc;
    logic [EW-1:0]  lz_ext;
    logic [EWR-1:0] shift_next;
    logic           dir_next;
    logic [EW-1:0]  exp_next;
    logic           zero_next;
    logic           ovf_next;
    logic           unf_next;

    assign exp_inc = s1_exp_reg + EW'(1);
    assign lz_ext  = EW'(lz);

    always_comb begin
        shift_next = '0;
        dir_next   = LEFT;
        exp_next   = '0;
        zero_next  = 1'b0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (s1_carry_reg) begin
            shift_next = EWR'(1);
            dir_next   = RIGHT;
            exp_next   = exp_inc;
            ovf_next   = (exp_inc == {EW{1'b1}});
        end else if (s1_zero_reg) begin
            zero_next = 1'b1;
        end else begin
            shift_next = lz;
`ifdef NORM_UNDERFLOW_DET_EN
            unf_next = (s1_exp_reg <= lz_ext);
            exp_next = unf_next ? '0 : (s1_exp_reg - lz_ext);
`else
            exp_next = s1_exp_reg - lz_ext;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Shift_Value_o <= '0;
            left_right_o  <= 1'b0;
            Exp_o         <= '0;
            zero_o        <= 1'b0;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            valid_o       <= 1'b0;
            load_o        <= 1'b0;
        end else begin
            valid_o <= s1_valid_reg;
            load_o  <= load_o | s1_valid_reg;
            if (s1_valid_reg) begin
                Shift_Value_o <= shift_next;
                left_right_o  <= dir_next;
                Exp_o         <= exp_next;
                zero_o        <= zero_next;
                overflow_o    <= ovf_next;
                underflow_o   <= unf_next;
            end
        end
    end

endmodule
